// File: rtl/axi_rdata_fifo.sv
// axi_rdata_fifo: AXI R-channel beat buffer feeding the pixel de-serialiser.
// FWFT head word on idata/ivalid, popped by ird_en; frame-start align pulse.
//
// Ports:
//   clock, rst_n      : clock, synchronous active-low reset
//   flush             : frame-start clear (pointers, count, bursts, underrun)
//   s_rvalid/s_rready : AXI R handshake; s_rdata/s_rlast beat payload
//   ird_en            : consumer pop of the head word
//   idata/ivalid      : head word and its valid (FIFO not empty)
//   ialign            : one-cycle pulse on first valid word after flush/reset
//   count             : words stored; almost_full = count >= AF_LEVEL
//   underrun          : sticky, pop attempted while empty
//   burst_cnt         : accepted last beats since flush
module axi_rdata_fifo #(
  parameter int DSIZE    = 256,
  parameter int DEPTH    = 16,
  parameter int AWIDTH   = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [DSIZE-1:0]  s_rdata,
  input  logic              s_rlast,
  input  logic              ird_en,
  output logic [DSIZE-1:0]  idata,
  output logic              ivalid,
  output logic              ialign,
  output logic [AWIDTH:0]   count,
  output logic              almost_full,
  output logic              underrun,
  output logic [15:0]       burst_cnt
);

  typedef enum logic {
    ARMED = 1'b0,
    IDLE  = 1'b1
  } align_t;

  logic [DSIZE-1:0]  mem [DEPTH];
  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic [AWIDTH:0]   count_next;
  logic              push;
  logic              pop;
  align_t            state;
  align_t            state_next;
  logic              ialign_d;

  assign push   = s_rvalid & s_rready;
  assign ivalid = (count != '0);
  assign pop    = ird_en & ivalid;
  assign idata  = mem[rd_ptr];

  assign count_next = count
                    + (AWIDTH+1)'(push)
                    - (AWIDTH+1)'(pop);

  assign almost_full =
    (count >= (AWIDTH+1)'(AF_LEVEL));

  always_ff @(posedge clock) begin
    if (rst_n && !flush && push) begin
      mem[wr_ptr] <= s_rdata;
    end
  end

  // Ready looks at the post-update count, so a full FIFO stays
  // not-ready for the cycle of a pop and reopens one cycle later.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      s_rready  <= 1'b0;
      underrun  <= 1'b0;
      burst_cnt <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      s_rready  <= 1'b0;
      underrun  <= 1'b0;
      burst_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count    <= count_next;
      s_rready <=
        (count_next <= (AWIDTH+1)'(DEPTH-1));
      if (ird_en && !ivalid) begin
        underrun <= 1'b1;
      end
      if (push && s_rlast) begin
        burst_cnt <= burst_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state <= ARMED;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (1'b1)
      flush: begin
        state_next = ARMED;
      end
      (state == ARMED)
        && (count_next != '0): begin
        state_next = IDLE;
      end
      default: begin
        state_next = state;
      end
    endcase
  end

  // Pulse is registered against count_next so it lands in the
  // same cycle ivalid first goes high.
  always_comb begin
    ialign_d = (state == ARMED)
             & ~flush
             & (count_next != '0);
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      ialign <= 1'b0;
    end else begin
      ialign <= ialign_d;
    end
  end

endmodule

// File: tb/tb_axi_rdata_fifo.sv
// tb_axi_rdata_fifo: directed stimulus with a scoreboard queue.
// Accepted beats are queued; a monitor checks each popped head word.
module tb_axi_rdata_fifo;

  localparam int DSIZE  = 256;
  localparam int DEPTH  = 16;
  localparam int AWIDTH = 4;
  localparam int AF     = 12;

  logic              clock = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              s_rvalid;
  logic              s_rready;
  logic [DSIZE-1:0]  s_rdata;
  logic              s_rlast;
  logic              ird_en;
  logic [DSIZE-1:0]  idata;
  logic              ivalid;
  logic              ialign;
  logic [AWIDTH:0]   count;
  logic              almost_full;
  logic              underrun;
  logic [15:0]       burst_cnt;

  logic [DSIZE-1:0]  exp_q [$];
  int                pass_cnt = 0;
  int                total_cnt = 0;

  always #5 clock = ~clock;

  axi_rdata_fifo #(
    .DSIZE(DSIZE), .DEPTH(DEPTH),
    .AWIDTH(AWIDTH), .AF_LEVEL(AF)
  ) dut (
    .clock(clock), .rst_n(rst_n),
    .flush(flush), .s_rvalid(s_rvalid),
    .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rlast(s_rlast), .ird_en(ird_en),
    .idata(idata), .ivalid(ivalid),
    .ialign(ialign), .count(count),
    .almost_full(almost_full),
    .underrun(underrun),
    .burst_cnt(burst_cnt)
  );

  task automatic chk(input string name,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s got=%0h exp=%0h",
               name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: pop compare first, then record accepted beat.
  always @(negedge clock) begin
    if (rst_n && !flush) begin
      if (ird_en && ivalid) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", 1, 0);
        end else begin
          chk("pop_data", idata, exp_q.pop_front());
        end
      end
      if (s_rvalid && s_rready) begin
        exp_q.push_back(s_rdata);
      end
    end
  end

  initial begin
    logic [DSIZE-1:0] a5;
    logic [DSIZE-1:0] x5a;
    a5  = {32{8'hA5}};
    x5a = {32{8'h5A}};
    rst_n = 1'b0; flush = 1'b0;
    s_rvalid = 1'b0; s_rdata = '0;
    s_rlast = 1'b0; ird_en = 1'b0;
    repeat (3) tick();
    chk("rst_ready", s_rready, 0);
    chk("rst_ivalid", ivalid, 0);
    chk("rst_count", count, 0);
    chk("rst_ialign", ialign, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_burst", burst_cnt, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready0", s_rready, 0);
    tick();
    chk("rel_ready1", s_rready, 1);
    tick();
    chk("idle_ivalid", ivalid, 0);
    chk("idle_count", count, 0);

    // Fill to full, data 0..15.
    s_rvalid = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      s_rdata = DSIZE'(k);
      chk("fill_ready", s_rready, 1);
      tick();
      chk("fill_count", count, k + 1);
      chk("fill_af", almost_full, (k + 1) >= AF);
      if (k == 0) chk("fill_ialign1", ialign, 1);
      if (k == 1) chk("fill_ialign0", ialign, 0);
    end
    chk("full_ready", s_rready, 0);
    s_rdata = DSIZE'(16);
    repeat (3) tick();
    chk("full_no17", count, DEPTH);
    chk("full_ready2", s_rready, 0);
    s_rvalid = 1'b0;

    // Drain 0..15.
    ird_en = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      tick();
      if (k == 0) chk("drain_ready", s_rready, 1);
      chk("drain_count", count, DEPTH - k - 1);
    end
    ird_en = 1'b0;
    chk("drain_ivalid", ivalid, 0);
    chk("drain_underrun", underrun, 0);
    chk("drain_q", exp_q.size(), 0);

    // Stream at count 5 across pointer wrap.
    s_rvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      s_rdata = DSIZE'(100 + k);
      tick();
    end
    chk("stream_pre", count, 5);
    ird_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      s_rdata = DSIZE'(200 + k);
      tick();
      chk("stream_count", count, 5);
    end
    s_rvalid = 1'b0;
    repeat (5) tick();
    ird_en = 1'b0;
    chk("stream_empty", ivalid, 0);
    chk("stream_q", exp_q.size(), 0);

    // Flush with 7 stored, a push offered in the flush cycle.
    s_rvalid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      s_rdata = DSIZE'(300 + k);
      tick();
    end
    chk("pre_flush", count, 7);
    s_rdata = DSIZE'(999);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    s_rvalid = 1'b0;
    exp_q.delete();
    chk("flush_count", count, 0);
    chk("flush_ivalid", ivalid, 0);
    chk("flush_ready", s_rready, 0);
    tick();
    chk("flush_ready1", s_rready, 1);
    chk("flush_noalign", ialign, 0);
    s_rvalid = 1'b1;
    s_rdata = a5;
    tick();
    s_rvalid = 1'b0;
    chk("align_pulse", ialign, 1);
    chk("align_ivalid", ivalid, 1);
    chk("align_data", idata, a5);
    tick();
    chk("align_once", ialign, 0);
    s_rvalid = 1'b1;
    s_rdata = x5a;
    tick();
    s_rvalid = 1'b0;
    chk("align_second", ialign, 0);
    tick();
    chk("align_second2", ialign, 0);
    ird_en = 1'b1;
    repeat (2) tick();
    ird_en = 1'b0;
    chk("align_drained", ivalid, 0);

    // Underrun is sticky.
    ird_en = 1'b1;
    tick();
    ird_en = 1'b0;
    chk("underrun_set", underrun, 1);
    tick();
    chk("underrun_hold", underrun, 1);

    // Three bursts of four beats.
    s_rvalid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      s_rdata = DSIZE'(500 + k);
      s_rlast = (k % 4) == 3;
      tick();
    end
    s_rvalid = 1'b0;
    s_rlast = 1'b0;
    chk("burst_cnt", burst_cnt, 3);
    chk("burst_af", almost_full, 1);
    chk("burst_underrun", underrun, 1);
    ird_en = 1'b1;
    repeat (12) tick();
    ird_en = 1'b0;
    chk("burst_q", exp_q.size(), 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_underrun", underrun, 0);
    chk("flush_burst", burst_cnt, 0);

    // Reset mid-operation.
    tick();
    s_rvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s_rdata = DSIZE'(700 + k);
      tick();
    end
    s_rvalid = 1'b0;
    rst_n = 1'b0;
    tick();
    exp_q.delete();
    chk("mid_rst_count", count, 0);
    chk("mid_rst_ready", s_rready, 0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("post_rst_ready", s_rready, 1);
    s_rvalid = 1'b1;
    s_rdata = DSIZE'(800);
    tick();
    s_rvalid = 1'b0;
    chk("post_rst_align", ialign, 1);
    ird_en = 1'b1;
    tick();
    ird_en = 1'b0;
    chk("final_q", exp_q.size(), 0);
    chk("final_ivalid", ivalid, 0);

    $display("%0d/%0d checks passed",
             pass_cnt, total_cnt);
    $finish;
  end

endmodule
